multi_cycle_ctrl: RTL and testbench

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/multi_cycle_ctrl_pkg.sv | 45 ++++
 rtl/multi_cycle_ctrl_op_decode.sv | 53 +++++
 rtl/multi_cycle_ctrl.sv | 140 ++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller.
// Holds FSM states, opcodes, ALUop codes and instruction classes.
package multi_cycle_ctrl_pkg;

   typedef enum logic [2:0] {
      S_INIT = 3'd0,
      S_IF   = 3'd1,
      S_ID   = 3'd2,
      S_EX   = 3'd3,
      S_MEM  = 3'd4,
      S_WB   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_NOP = 3'd0,
      C_R   = 3'd1,
      C_IMM = 3'd2,
      C_LW  = 3'd3,
      C_SW  = 3'd4,
      C_BEQ = 3'd5,
      C_BNE = 3'd6,
      C_J   = 3'd7
   } cls_t;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_SLT  = 3'b010;
   localparam logic [2:0] ALU_RTYP = 3'b011;
   localparam logic [2:0] ALU_AND  = 3'b100;
   localparam logic [2:0] ALU_OR   = 3'b101;
   localparam logic [2:0] ALU_XOR  = 3'b110;

endpackage

// File: rtl/multi_cycle_ctrl_op_decode.sv
// Opcode decoder: class, EX-state ALUop, supported flag.
// Ports: i_opcode in; o_cls, o_alu_op, o_supported out.
module ctrl_op_decode
   import multi_cycle_ctrl_pkg::*;
(
   input  logic [5:0] i_opcode,
   output cls_t       o_cls,
   output logic [2:0] o_alu_op,
   output logic       o_supported
);

   always_comb begin
      o_cls       = C_NOP;
      o_alu_op    = ALU_ADD;
      o_supported = 1'b1;
      case (i_opcode)
         OP_R: begin
            o_cls    = C_R;
            o_alu_op = ALU_RTYP;
         end
         OP_ADDIU: o_cls = C_IMM;
         OP_SLTI: begin
            o_cls    = C_IMM;
            o_alu_op = ALU_SLT;
         end
         OP_ANDI: begin
            o_cls    = C_IMM;
            o_alu_op = ALU_AND;
         end
         OP_ORI: begin
            o_cls    = C_IMM;
            o_alu_op = ALU_OR;
         end
         OP_XORI: begin
            o_cls    = C_IMM;
            o_alu_op = ALU_XOR;
         end
         OP_LW: o_cls = C_LW;
         OP_SW: o_cls = C_SW;
         OP_BEQ: begin
            o_cls    = C_BEQ;
            o_alu_op = ALU_SUB;
         end
         OP_BNE: begin
            o_cls    = C_BNE;
            o_alu_op = ALU_SUB;
         end
         OP_J: o_cls = C_J;
         default: o_supported = 1'b0;
      endcase
   end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM: IF, ID, EX, MEM, WB.
// Ports: clk, resetn, opcode, func, zero, mem_ready in; datapath strobes/selects and state_o out.
module multi_cycle_ctrl
   import multi_cycle_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic [5:0] opcode,
   input  logic [5:0] func,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       inst_req,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IR_write,
   output logic       PC_write,
   output logic       PC_write_cond,
   output logic [1:0] PCSource,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUop,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic [2:0] state_o
);

   state_t     r_state;
   state_t     w_next;
   cls_t       w_cls;
   logic [2:0] w_ex_aop;
   logic       w_sup;

   // func is decoded by the ALU control unit, not here
   logic w_unused;
   assign w_unused = ^func;

   ctrl_op_decode u_dec (
      .i_opcode    (opcode),
      .o_cls       (w_cls),
      .o_alu_op    (w_ex_aop),
      .o_supported (w_sup)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_INIT;
      else         r_state <= w_next;
   end

   assign state_o = r_state;

   always_comb begin
      w_next        = S_INIT;
      inst_req      = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IR_write      = 1'b0;
      PC_write      = 1'b0;
      PC_write_cond = 1'b0;
      PCSource      = 2'b00;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      ALUop         = ALU_ADD;
      RegWrite      = 1'b0;
      RegDst        = 1'b0;
      MemtoReg      = 1'b0;
      case (r_state)
         S_INIT: w_next = S_IF;
         S_IF: begin
            inst_req = 1'b1;
            ALUSrcB  = 2'b01;
            if (mem_ready) begin
               IR_write = 1'b1;
               PC_write = 1'b1;
               w_next   = S_ID;
            end else begin
               w_next = S_IF;
            end
         end
         S_ID: begin
            // precompute branch target into ALUOut
            ALUSrcB = 2'b11;
            if (w_cls == C_J) begin
               PC_write = 1'b1;
               PCSource = 2'b10;
               w_next   = S_IF;
            end else if (!w_sup) begin
               w_next = S_IF;
            end else begin
               w_next = S_EX;
            end
         end
         S_EX: begin
            ALUSrcA = 1'b1;
            ALUop   = w_ex_aop;
            case (w_cls)
               C_R: w_next = S_WB;
               C_IMM: begin
                  ALUSrcB = 2'b10;
                  w_next  = S_WB;
               end
               C_LW, C_SW: begin
                  ALUSrcB = 2'b10;
                  w_next  = S_MEM;
               end
               C_BEQ: begin
                  PCSource      = 2'b01;
                  PC_write_cond = zero;
                  w_next        = S_IF;
               end
               C_BNE: begin
                  PCSource      = 2'b01;
                  PC_write_cond = ~zero;
                  w_next        = S_IF;
               end
               default: w_next = S_IF;
            endcase
         end
         S_MEM: begin
            if (w_cls == C_LW) begin
               MemRead = 1'b1;
               w_next  = mem_ready ? S_WB : S_MEM;
            end else if (w_cls == C_SW) begin
               MemWrite = 1'b1;
               w_next   = mem_ready ? S_IF : S_MEM;
            end else begin
               w_next = S_IF;
            end
         end
         S_WB: begin
            RegWrite = 1'b1;
            RegDst   = (w_cls == C_R);
            MemtoReg = (w_cls == C_LW);
            w_next   = S_IF;
         end
         default: w_next = S_INIT;
      endcase
   end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl.
// Directed per-cycle vectors; monitor pops and compares each negedge.
module tb_multi_cycle_ctrl;

   typedef struct packed {
      logic [2:0] st;
      logic       ir, mr, mw, irw, pcw, pcc;
      logic [1:0] pcs;
      logic       sa;
      logic [1:0] sb;
      logic [2:0] aop;
      logic       rw, rd, m2r;
   } out_t;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [5:0] opcode = '0;
   logic [5:0] func = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       inst_req, MemRead, MemWrite, IR_write, PC_write;
   logic       PC_write_cond, ALUSrcA, RegWrite, RegDst, MemtoReg;
   logic [1:0] PCSource, ALUSrcB;
   logic [2:0] ALUop, state_o;

   int n_chk = 0;
   int n_fail = 0;
   out_t  exp_q[$];
   string nam_q[$];

   multi_cycle_ctrl dut (
      .clk(clk), .resetn(resetn), .opcode(opcode), .func(func),
      .zero(zero), .mem_ready(mem_ready), .inst_req(inst_req),
      .MemRead(MemRead), .MemWrite(MemWrite), .IR_write(IR_write),
      .PC_write(PC_write), .PC_write_cond(PC_write_cond),
      .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUop(ALUop), .RegWrite(RegWrite), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .state_o(state_o)
   );

   always #5 clk = ~clk;

   function automatic out_t o_init();
      return '0;
   endfunction

   function automatic out_t o_if(bit rdy);
      out_t e = '0;
      e.st = 3'd1; e.ir = 1'b1; e.sb = 2'b01;
      e.irw = rdy; e.pcw = rdy;
      return e;
   endfunction

   function automatic out_t o_id(bit pcw, logic [1:0] pcs);
      out_t e = '0;
      e.st = 3'd2; e.sb = 2'b11; e.pcw = pcw; e.pcs = pcs;
      return e;
   endfunction

   function automatic out_t o_ex(logic [2:0] aop, logic [1:0] sb,
                                 bit pcc, logic [1:0] pcs);
      out_t e = '0;
      e.st = 3'd3; e.sa = 1'b1; e.aop = aop; e.sb = sb;
      e.pcc = pcc; e.pcs = pcs;
      return e;
   endfunction

   function automatic out_t o_mem(bit mr, bit mw);
      out_t e = '0;
      e.st = 3'd4; e.mr = mr; e.mw = mw;
      return e;
   endfunction

   function automatic out_t o_wb(bit rd, bit m2r);
      out_t e = '0;
      e.st = 3'd5; e.rw = 1'b1; e.rd = rd; e.m2r = m2r;
      return e;
   endfunction

   // one clock of stimulus; mid asserts reset inside the cycle
   task automatic cyc(bit rn, logic [5:0] op, logic [5:0] fn, bit z,
                      bit rdy, out_t e, string nm, bit mid = 1'b0);
      @(posedge clk);
      #1;
      resetn = rn; opcode = op; func = fn; zero = z; mem_ready = rdy;
      exp_q.push_back(e);
      nam_q.push_back(nm);
      if (mid) begin
         #2;
         resetn = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         out_t e;
         out_t g;
         string nm;
         e  = exp_q.pop_front();
         nm = nam_q.pop_front();
         g  = {state_o, inst_req, MemRead, MemWrite, IR_write, PC_write,
               PC_write_cond, PCSource, ALUSrcA, ALUSrcB, ALUop,
               RegWrite, RegDst, MemtoReg};
         n_chk++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL %s got=%05h exp=%05h", nm, g, e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   logic [5:0] imm_op [4];
   logic [2:0] imm_aop [4];

   initial begin
      imm_op  = '{6'b001001, 6'b001010, 6'b001100, 6'b001110};
      imm_aop = '{3'b000,    3'b010,    3'b100,    3'b110};

      cyc(0, 6'h00, 6'h00, 0, 1, o_init(), "rst_hold0");
      cyc(0, 6'h00, 6'h00, 0, 1, o_init(), "rst_hold1");
      cyc(1, 6'h00, 6'h00, 0, 1, o_init(), "init_first");

      // addu, IF stalled once
      cyc(1, 6'h00, 6'h21, 0, 0, o_if(0), "if_stall");
      cyc(1, 6'h00, 6'h21, 0, 1, o_if(1), "addu_if");
      cyc(1, 6'h00, 6'h21, 0, 1, o_id(0, 2'b00), "addu_id");
      cyc(1, 6'h00, 6'h21, 0, 1, o_ex(3'b011, 2'b00, 0, 2'b00), "addu_ex");
      cyc(1, 6'h00, 6'h21, 0, 1, o_wb(1, 0), "addu_wb");

      // lw with two wait cycles in MEM
      cyc(1, 6'h23, 6'h00, 0, 1, o_if(1), "lw_if");
      cyc(1, 6'h23, 6'h00, 0, 1, o_id(0, 2'b00), "lw_id");
      cyc(1, 6'h23, 6'h00, 0, 1, o_ex(3'b000, 2'b10, 0, 2'b00), "lw_ex");
      cyc(1, 6'h23, 6'h00, 0, 0, o_mem(1, 0), "lw_mem0");
      cyc(1, 6'h23, 6'h00, 0, 0, o_mem(1, 0), "lw_mem1");
      cyc(1, 6'h23, 6'h00, 0, 1, o_mem(1, 0), "lw_mem2");
      cyc(1, 6'h23, 6'h00, 0, 1, o_wb(0, 1), "lw_wb");

      // beq taken / not taken
      cyc(1, 6'h04, 6'h00, 1, 1, o_if(1), "beq1_if");
      cyc(1, 6'h04, 6'h00, 1, 1, o_id(0, 2'b00), "beq1_id");
      cyc(1, 6'h04, 6'h00, 1, 1, o_ex(3'b001, 2'b00, 1, 2'b01), "beq1_ex");
      cyc(1, 6'h04, 6'h00, 0, 1, o_if(1), "beq0_if");
      cyc(1, 6'h04, 6'h00, 0, 1, o_id(0, 2'b00), "beq0_id");
      cyc(1, 6'h04, 6'h00, 0, 1, o_ex(3'b001, 2'b00, 0, 2'b01), "beq0_ex");

      // bne both ways
      cyc(1, 6'h05, 6'h00, 0, 1, o_if(1), "bne0_if");
      cyc(1, 6'h05, 6'h00, 0, 1, o_id(0, 2'b00), "bne0_id");
      cyc(1, 6'h05, 6'h00, 0, 1, o_ex(3'b001, 2'b00, 1, 2'b01), "bne0_ex");
      cyc(1, 6'h05, 6'h00, 1, 1, o_if(1), "bne1_if");
      cyc(1, 6'h05, 6'h00, 1, 1, o_id(0, 2'b00), "bne1_id");
      cyc(1, 6'h05, 6'h00, 1, 1, o_ex(3'b001, 2'b00, 0, 2'b01), "bne1_ex");

      // unsupported opcode, then jump
      cyc(1, 6'h3f, 6'h00, 0, 1, o_if(1), "bad_if");
      cyc(1, 6'h3f, 6'h00, 0, 1, o_id(0, 2'b00), "bad_id");
      cyc(1, 6'h02, 6'h00, 0, 1, o_if(1), "j_if");
      cyc(1, 6'h02, 6'h00, 0, 1, o_id(1, 2'b10), "j_id");

      // immediate ALU classes
      for (int i = 0; i < 4; i++) begin
         cyc(1, imm_op[i], 6'h00, 0, 1, o_if(1), "imm_if");
         cyc(1, imm_op[i], 6'h00, 0, 1, o_id(0, 2'b00), "imm_id");
         cyc(1, imm_op[i], 6'h00, 0, 1,
             o_ex(imm_aop[i], 2'b10, 0, 2'b00), "imm_ex");
         cyc(1, imm_op[i], 6'h00, 0, 1, o_wb(0, 0), "imm_wb");
      end
      cyc(1, 6'h0d, 6'h00, 0, 1, o_if(1), "ori_if");
      cyc(1, 6'h0d, 6'h00, 0, 1, o_id(0, 2'b00), "ori_id");
      cyc(1, 6'h0d, 6'h00, 0, 1, o_ex(3'b101, 2'b10, 0, 2'b00), "ori_ex");
      cyc(1, 6'h0d, 6'h00, 0, 1, o_wb(0, 0), "ori_wb");

      // sw, no wait
      cyc(1, 6'h2b, 6'h00, 0, 1, o_if(1), "sw_if");
      cyc(1, 6'h2b, 6'h00, 0, 1, o_id(0, 2'b00), "sw_id");
      cyc(1, 6'h2b, 6'h00, 0, 1, o_ex(3'b000, 2'b10, 0, 2'b00), "sw_ex");
      cyc(1, 6'h2b, 6'h00, 0, 1, o_mem(0, 1), "sw_mem");

      // sw stalled, reset pulsed mid-handshake
      cyc(1, 6'h2b, 6'h00, 0, 1, o_if(1), "sw2_if");
      cyc(1, 6'h2b, 6'h00, 0, 1, o_id(0, 2'b00), "sw2_id");
      cyc(1, 6'h2b, 6'h00, 0, 1, o_ex(3'b000, 2'b10, 0, 2'b00), "sw2_ex");
      cyc(1, 6'h2b, 6'h00, 0, 0, o_init(), "sw2_mem_rst", 1'b1);
      cyc(0, 6'h2b, 6'h00, 0, 0, o_init(), "rst_in_mem");
      cyc(1, 6'h2b, 6'h00, 0, 0, o_init(), "init_after_rst");
      cyc(1, 6'h2b, 6'h00, 0, 0, o_if(0), "if_after_rst");

      repeat (3) @(posedge clk);
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain got=%0d left expected=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
